// File: rtl/sort_seq.sv
// Load/sort/drain sequencer: loads N words, bubble-sorts them ascending with one
//   compare-swap per cycle (early exit on a clean pass), then streams them out.
// Latency: last input beat to first output is P*(N-1)+1 cycles, P = passes used.
// Backpressure: in_valid/in_ready during LOAD, out_valid/out_ready during DRAIN;
//   outputs are held while out_ready is low and come from registers only.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data    input word stream (ready only in LOAD)
//   out_valid/out_ready/out_data/out_last  sorted output stream (DRAIN only)
//   busy              high while sorting
//   passes            passes used by the most recent completed sort
module sort_seq #(
  parameter int N  = 8,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [$clog2(N)-1:0] passes
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] J_LAST = KW'(N - 2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q [N];
  logic [DW-1:0]   a_d [N];
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   j_q, j_d;
  logic [KW-1:0]   pc_q, pc_d;
  logic [KW-1:0]   passes_q, passes_d;
  logic            sw_q, sw_d;

  logic [KW-1:0]   j_nxt;
  logic [KW-1:0]   pc_next;
  logic [DW-1:0]   cmp_lo, cmp_hi;
  logic            do_swap;
  logic            swapped;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      for (int i = 0; i < N; i++) a_q[i] <= '0;
      k_q      <= '0;
      j_q      <= '0;
      pc_q     <= '0;
      passes_q <= '0;
      sw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      k_q      <= k_d;
      j_q      <= j_d;
      pc_q     <= pc_d;
      passes_q <= passes_d;
      sw_q     <= sw_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    k_d      = k_q;
    j_d      = j_q;
    pc_d     = pc_q;
    passes_d = passes_q;
    sw_d     = sw_q;

    // Shared compare-swap unit, always looking at the pair (j, j+1).
    j_nxt    = j_q + KW'(1);
    pc_next  = pc_q + KW'(1);
    cmp_lo   = a_q[j_q];
    cmp_hi   = a_q[j_nxt];
    do_swap  = cmp_lo > cmp_hi;      // strict: equal words keep their order
    swapped  = sw_q | do_swap;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          a_d[k_q] = in_data;
          if (k_q == K_LAST) begin
            k_d     = '0;
            j_d     = '0;
            sw_d    = 1'b0;
            pc_d    = '0;
            state_d = ST_SORT;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      ST_SORT: begin
        if (do_swap) begin
          a_d[j_q]   = cmp_hi;
          a_d[j_nxt] = cmp_lo;
        end
        if (j_q != J_LAST) begin
          j_d  = j_nxt;
          sw_d = swapped;
        end else if (!swapped || pc_next == K_LAST) begin
          // Clean pass, or the N-1 pass bound that guarantees sorted order.
          passes_d = pc_next;
          state_d  = ST_DRAIN;       // k is already 0 from the load
        end else begin
          j_d  = '0;
          sw_d = 1'b0;
          pc_d = pc_next;
        end
      end

      ST_DRAIN: begin
        if (out_ready) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_LOAD;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q == ST_SORT);
  assign out_data  = (state_q == ST_DRAIN) ? a_q[k_q] : '0;
  assign out_last  = (state_q == ST_DRAIN) && (k_q == K_LAST);
  assign passes    = passes_q;

endmodule

// File: tb/tb_sort_seq.sv
// Bench for sort_seq: directed jobs, reference model from sorted order and
// inversion depth, per-cycle protocol checks and a scoreboard on the output.
module tb_sort_seq;

  typedef logic [7:0] word_t;

  bit         clk;
  logic       reset;
  logic       in_valid;
  word_t      in_data;
  logic       in_ready;
  logic       out_valid;
  word_t      out_data;
  logic       out_last;
  bit         out_ready;
  logic       busy;
  logic [2:0] passes;

  int errors = 0;
  int checks = 0;
  bit rdy_mode = 1'b0;

  word_t exp_q[$];
  bit    exp_last_q[$];
  int    exp_p_q[$];

  sort_seq #(.N(8), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .passes(passes)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic check(input bit cond, input string name, input int act, input int req);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Passes = deepest leftward travel of any word (count of larger words before
  // it) plus one clean confirmation pass, capped at N-1.
  function automatic int model_passes(input word_t d[8]);
    int mx = 0;
    for (int i = 0; i < 8; i++) begin
      int c = 0;
      for (int j = 0; j < i; j++) if (d[j] > d[i]) c++;
      if (c > mx) mx = c;
    end
    return (mx + 1 > 7) ? 7 : mx + 1;
  endfunction

  task automatic model_sort(input word_t d[8], output word_t s[8]);
    word_t q[$];
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    q.sort();
    for (int i = 0; i < 8; i++) s[i] = q[i];
  endtask

  task automatic run_job(input word_t d[8], input bit vld_rand, input bit keep_vld);
    int idx = 0;
    int budget = 0;
    bit acc;
    word_t s[8];
    @(posedge clk); #1;
    while (idx < 8) begin
      in_valid = vld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = d[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      budget++;
      if (budget > 500) begin
        check(1'b0, "load_timeout", idx, 8);
        break;
      end
    end
    in_valid = keep_vld;
    model_sort(d, s);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(s[i]);
      exp_last_q.push_back(i == 7);
    end
    exp_p_q.push_back(model_passes(d));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 || exp_p_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin
        check(1'b0, "drain_timeout", exp_q.size(), 0);
        break;
      end
    end
  endtask

  // Per-cycle compare process.
  bit    rst_prev = 1'b1, busy_prev = 1'b0, stall_prev = 1'b0, last_hs_prev = 1'b0;
  int    busy_cnt = 0;
  int    passes_prev = 0;
  word_t data_prev;
  bit    lastf_prev;

  always @(negedge clk) begin
    if (rst_prev) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check(!in_ready && !out_valid, "sort_quiet", {in_ready, out_valid}, 0);
      end
      if (busy_prev && !busy) begin
        check(out_valid, "first_out_latency", out_valid, 1);
        if (exp_p_q.size() != 0) begin
          int p;
          p = exp_p_q.pop_front();
          check(busy_cnt == p * 7, "busy_cycles", busy_cnt, p * 7);
          check(passes == p, "passes", passes, p);
        end else begin
          check(1'b0, "unexpected_sort_end", busy_cnt, 0);
        end
        busy_cnt = 0;
      end
      if (int'(passes) != passes_prev)
        check(busy_prev && !busy, "passes_update_time", passes, passes_prev);
      if (stall_prev)
        check(out_valid && out_data == data_prev && out_last == lastf_prev,
              "stall_stable", out_data, data_prev);
      if (last_hs_prev)
        check(in_ready && !out_valid, "reload_after_last", in_ready, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "extra_word", out_data, 0);
        end else begin
          word_t w;
          bit    l;
          w = exp_q.pop_front();
          l = exp_last_q.pop_front();
          check(out_data == w, "out_data", out_data, w);
          check(out_last == l, "out_last", out_last, l);
        end
      end
    end
    busy_prev    = busy;
    passes_prev  = int'(passes);
    stall_prev   = out_valid && !out_ready;
    data_prev    = out_data;
    lastf_prev   = out_last;
    last_hs_prev = out_valid && out_ready && out_last;
    rst_prev     = reset;
  end

  initial begin
    word_t nominal[8], best[8], worst[8], stress[8], fresh[8], b1[8], b2[8];
    word_t lit[8], s[8];
    int n;
    nominal = '{8'd4, 8'd5, 8'd1, 8'd3, 8'd2, 8'd6, 8'd8, 8'd7};
    best    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    worst   = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    stress  = '{8'd255, 8'd0, 8'd128, 8'd128, 8'd1, 8'd254, 8'd7, 8'd7};
    fresh   = '{8'd2, 8'd1, 8'd4, 8'd3, 8'd6, 8'd5, 8'd8, 8'd7};
    b1      = '{8'd9, 8'd3, 8'd200, 8'd3, 8'd50, 8'd1, 8'd77, 8'd12};
    b2      = '{8'd60, 8'd61, 8'd5, 8'd6, 8'd250, 8'd0, 8'd33, 8'd32};
    lit     = '{8'd0, 8'd1, 8'd7, 8'd7, 8'd128, 8'd128, 8'd254, 8'd255};

    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(passes == 3'd0, "rst_passes", passes, 0);
    check(out_data == 8'd0, "rst_out_data", out_data, 0);
    check(out_last == 1'b0, "rst_out_last", out_last, 0);

    // Hand-computed pins on the model itself.
    check(model_passes(nominal) == 4, "model_p_nominal", model_passes(nominal), 4);
    check(model_passes(best) == 1, "model_p_best", model_passes(best), 1);
    check(model_passes(worst) == 7, "model_p_worst", model_passes(worst), 7);
    check(model_passes(stress) == 5, "model_p_stress", model_passes(stress), 5);
    model_sort(stress, s);
    for (int i = 0; i < 8; i++) check(s[i] == lit[i], "model_sort_stress", s[i], lit[i]);

    run_job(nominal, 1'b0, 1'b0); wait_idle();
    run_job(best,    1'b0, 1'b0); wait_idle();
    run_job(worst,   1'b0, 1'b0); wait_idle();

    rdy_mode = 1'b1;
    run_job(stress, 1'b1, 1'b0); wait_idle();
    rdy_mode = 1'b0;

    // Reset in the middle of a sort.
    run_job(nominal, 1'b0, 1'b0);
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    check(busy == 1'b1, "reached_sort", busy, 1);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); exp_last_q.delete(); exp_p_q.delete();
    @(negedge clk);
    check(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
    check(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(passes == 3'd0, "midrst_passes", passes, 0);
    run_job(fresh, 1'b0, 1'b0); wait_idle();

    // Back-to-back jobs with in_valid and out_ready held high.
    run_job(b1, 1'b0, 1'b1);
    run_job(b2, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_seq.md
# sort_seq

Load/sort/drain sequencer for the 8-entry bubble-sort datapath. It accepts N unsigned words over a valid/ready input stream into an internal register array, then sorts them in ascending order. Sorting uses a single shared compare-swap step per cycle, and the block stops early once a pass makes no swaps. The sorted words are then streamed out over a valid/ready output with a last marker. It sits between a data source and a consumer and replaces free-running sort loops with a handshaken, restartable job flow.

## Interface
- N, 8, number of entries; power of two, 2..16
- DW, 8, word width, unsigned
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_valid  in  1  input word present
- in_data  in  DW  input word
- in_ready  out  1  block accepts input (state LOAD)
- out_valid  out  1  sorted word present (state DRAIN)
- out_data  out  DW  sorted word
- out_last  out  1  out_data is entry N-1
- out_ready  in  1  consumer accepts word
- busy  out  1  state SORT
- passes  out  clog2(N)  passes used by the most recent sort job

## Operation
- Storage: A[0..N-1], DW bits each. Index counter k (clog2(N) bits), compare index j, swap flag sw, pass counter pc.
- State LOAD:
  - in_ready=1.
  - On each in_valid&&in_ready: A[k]<=in_data, k++.
  - On the beat with k==N-1: k<=0, j<=0, sw<=0, pc<=0, go to SORT.
- State SORT:
  - busy=1. in_ready=0. out_valid=0.
  - Each cycle compares A[j] with A[j+1].
  - If A[j]>A[j+1] (strict, unsigned): swap the two, sw<=1. Equal values are never swapped.
  - If j<N-2: j++.
  - If j==N-2, the pass ends and pc_next=pc+1. Let swapped = sw OR this cycle's swap.
  - If !swapped, or pc_next==N-1: passes<=pc_next and go to DRAIN.
  - Otherwise: j<=0, sw<=0, pc<=pc_next.
- State DRAIN:
  - out_valid=1, out_data=A[k], out_last=(k==N-1).
  - On each out_valid&&out_ready: k++.
  - On the handshake with k==N-1: k<=0, go to LOAD.
  - out_data and out_last are held stable while out_ready=0.
- passes holds its value from one job until the next sort completes.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
- Reset:
  - A[*]<=0, k=j=pc=0, sw=0, passes=0, state LOAD.
  - Outputs after the reset edge: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
  - Reset in any state, including mid-LOAD, mid-SORT and mid-DRAIN, discards the job. No partial output follows.

## Timing
- Load: 1 word per cycle at best. SORT begins the cycle after the Nth accepted beat.
- Sort: exactly one compare per cycle, N-1 cycles per pass. Total SORT cycles = P*(N-1), where P = final passes value, 1 <= P <= N-1.
- The first sorted word is valid in the cycle after the final compare. Job latency, last input beat to first output, is P*(N-1)+1 cycles.
- Drain: 1 word per cycle with out_ready held at 1. LOAD resumes the cycle after the last beat. No bubble is inserted between jobs beyond that single state-change cycle.
- Outputs are decoded from state and registers only. There is no combinational path from in_* or out_ready to out_*.

## Test plan
- Nominal job:
  - Load 4,5,1,3,2,6,8,7 with in_valid held high.
  - Required: output 1,2,3,4,5,6,7,8, out_last only on 8, passes=4, busy high for exactly 28 cycles.
- Best case:
  - Load 1..8 ascending.
  - Required: passes=1, busy for 7 cycles, output identical to input.
- Worst case:
  - Load 8,7,...,1.
  - Required: passes=7 (cap), busy for 49 cycles, output 1..8.
- Handshake stress:
  - Randomly deassert in_valid during LOAD and out_ready during DRAIN; load 255,0,128,128,1,254,7,7.
  - Required: output 0,1,7,7,128,128,254,255. out_data and out_last are stable while stalled. No word is lost or duplicated. in_ready=0 and out_valid=0 throughout SORT.
- Reset mid-operation:
  - Assert reset for 1 cycle during SORT of the nominal job.
  - Required: next cycle in_ready=1, out_valid=0, busy=0, passes=0. A following fresh load of 2,1,... sorts correctly.
- Back-to-back jobs:
  - Two nominal-type jobs with different data, out_ready and in_valid held at 1.
  - Required: second job's in_ready rises the cycle after the first job's out_last handshake. passes updates only at the end of the second sort.
